// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer driving PC mode, MAR/IR/memory strobes and the execute handshake.
// Define PC_SEQ_JZ_EN to add the zero_flag input and the conditional-jump (JZ) path.
module pc_sequencer #(
   parameter logic [7:0] JMP_OPCODE  = 8'h01,
   parameter logic [7:0] HALT_OPCODE = 8'hFF,
   parameter logic [7:0] JZ_OPCODE   = 8'h02
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       halt_req_i,
   input  logic       mem_ready_i,
   input  logic [7:0] ir_opcode_i,
   input  logic       exec_done_i,
`ifdef PC_SEQ_JZ_EN
   input  logic       zero_flag_i,
`endif
   output logic [2:0] pc_mode_o,
   output logic       mar_load_o,
   output logic       mem_oe_o,
   output logic       ir_load_o,
   output logic       exec_start_o,
   output logic       busy_o,
   output logic       halted_o
);
   localparam logic [2:0] PC_RST  = 3'd0;
   localparam logic [2:0] PC_LOAD = 3'd1;
   localparam logic [2:0] PC_BUS  = 3'd2;
   localparam logic [2:0] PC_HOLD = 3'd3;
   localparam logic [2:0] PC_INC  = 3'd4;

   typedef enum logic [3:0] {
      IDLE, CLR, ADDR, READ, DECODE, EXEC, INC, OPINC, OPADDR, OPREAD, HALT
`ifdef PC_SEQ_JZ_EN
      , SKIP1, SKIP2
`endif
   } state_t;

   state_t state_q, state_d, done_d;
   logic   jz_hit, jz_zf, is_jump;

   assign jz_hit = ir_opcode_i == JZ_OPCODE;
`ifdef PC_SEQ_JZ_EN
   assign jz_zf = zero_flag_i;
`else
   assign jz_zf = 1'b0;
`endif
   assign is_jump = (ir_opcode_i == JMP_OPCODE) || (jz_hit && jz_zf);
   // Where every instruction goes once its PC update is done.
   assign done_d  = halt_req_i ? HALT : ADDR;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      pc_mode_o    = PC_HOLD;
      mar_load_o   = 1'b0;
      mem_oe_o     = 1'b0;
      ir_load_o    = 1'b0;
      exec_start_o = 1'b0;
      case (state_q)
         IDLE:    state_d = start_i ? CLR : IDLE;
         CLR: begin
            pc_mode_o = PC_RST;
            state_d   = ADDR;
         end
         ADDR: begin
            pc_mode_o  = PC_BUS;
            mar_load_o = 1'b1;
            state_d    = READ;
         end
         READ: begin
            mem_oe_o  = 1'b1;
            ir_load_o = mem_ready_i;
            state_d   = mem_ready_i ? DECODE : READ;
         end
         DECODE:  state_d = (ir_opcode_i == HALT_OPCODE) ? HALT :
                            is_jump ? OPINC :
`ifdef PC_SEQ_JZ_EN
                            jz_hit ? SKIP1 :
`endif
                            EXEC;
         EXEC: begin
            exec_start_o = 1'b1;
            state_d      = exec_done_i ? INC : EXEC;
         end
         INC: begin
            pc_mode_o = PC_INC;
            state_d   = done_d;
         end
         OPINC: begin
            pc_mode_o = PC_INC;
            state_d   = OPADDR;
         end
         OPADDR: begin
            pc_mode_o  = PC_BUS;
            mar_load_o = 1'b1;
            state_d    = OPREAD;
         end
         OPREAD: begin
            mem_oe_o  = 1'b1;
            pc_mode_o = mem_ready_i ? PC_LOAD : PC_HOLD;
            state_d   = mem_ready_i ? done_d : OPREAD;
         end
         HALT:    state_d = start_i ? CLR : HALT;
`ifdef PC_SEQ_JZ_EN
         SKIP1: begin
            pc_mode_o = PC_INC;
            state_d   = SKIP2;
         end
         SKIP2: begin
            pc_mode_o = PC_INC;
            state_d   = done_d;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign busy_o   = (state_q != IDLE) && (state_q != HALT);
   assign halted_o = state_q == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: cycle traces for the directed scenarios plus an ISA-level scoreboard for random programs.
module tb_pc_sequencer;
   localparam logic [7:0] JMP = 8'h01, HLT_OP = 8'hFF, JZ = 8'h02;
`ifdef PC_SEQ_JZ_EN
   localparam bit JZ_EN = 1'b1;
`else
   localparam bit JZ_EN = 1'b0;
`endif
   localparam logic [5:0] IDL = 6'b000000, BSY = 6'b000010, HLT = 6'b000001;
   localparam logic [5:0] MA = 6'b100010, OE = 6'b010010, OEIR = 6'b011010, EX = 6'b000110;

   logic clk = 1'b0, reset, start, halt_force, auto_halt, rnd_mode, zf;
   logic [2:0] pc_mode;
   logic mar_load, mem_oe, ir_load, exec_start, busy, halted, mem_ready, halt_req, ex_prev = 1'b0;
   logic ex_rdy = 1'b1;
   logic [7:0] mem [256];
   logic [7:0] pc = 8'h00, mar = 8'h00, ir = 8'h00, bus;
   int wait_n = 0, rnd_lim = 0, rd_cnt = 0, opcnt = 0, K = 0;
   int compared = 0, mismatched = 0;
   logic [16:0] exp_cyc [$];
   logic [7:0]  addr_q [$], ex_q [$];

   pc_sequencer dut (
      .clock_i(clk), .reset_i(reset), .start_i(start), .halt_req_i(halt_req),
      .mem_ready_i(mem_ready), .ir_opcode_i(ir), .exec_done_i(ex_rdy),
`ifdef PC_SEQ_JZ_EN
      .zero_flag_i(zf),
`endif
      .pc_mode_o(pc_mode), .mar_load_o(mar_load), .mem_oe_o(mem_oe), .ir_load_o(ir_load),
      .exec_start_o(exec_start), .busy_o(busy), .halted_o(halted)
   );

   always #5 clk = ~clk;

   // Environment: PC, MAR, IR, memory with programmable wait states, execute unit.
   assign mem_ready = mem_oe && (rd_cnt >= (rnd_mode ? rnd_lim : wait_n));
   assign bus       = (pc_mode == 3'd2) ? pc : (mem_oe && mem_ready) ? mem[mar] : 8'h00;
   assign halt_req  = halt_force | (auto_halt && opcnt >= K);

   always @(posedge clk) begin
      pc      <= (pc_mode == 3'd0) ? 8'h00 : (pc_mode == 3'd1) ? bus : (pc_mode == 3'd4) ? pc + 8'd1 : pc;
      mar     <= mar_load ? bus : mar;
      ir      <= ir_load ? bus : ir;
      rd_cnt  <= (mem_oe && !mem_ready) ? rd_cnt + 1 : 0;
      rnd_lim <= mem_ready ? int'($urandom_range(0, 2)) : rnd_lim;
      ex_rdy  <= rnd_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
      opcnt   <= start ? 0 : opcnt + int'(ir_load);
   end

   task automatic check(input bit ok, input string nm, input int act, input int exp);
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic e(input logic [2:0] pm, input logic [5:0] f, input logic [7:0] a = 8'h00);
      exp_cyc.push_back({pm, f, a});
   endtask

   task automatic go(input int n);
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (n - 1) cyc();
   endtask

   task automatic wait_halt(input int lim);
      int n = 0;
      while (!halted && n < lim) begin
         cyc();
         n++;
      end
      check(halted, "halt_reached", int'(halted), 1);
   endtask

   task automatic trace_jmp();
      e(3, HLT); e(0, BSY); e(2, MA, 8'h00); e(3, OEIR); e(3, BSY); e(4, BSY);
      e(2, MA, 8'h01); e(1, OE); e(2, MA, 8'h40); e(3, OEIR); e(3, BSY); e(3, HLT);
   endtask

   // Reference: run the program instruction by instruction, listing fetch addresses and executed opcodes.
   task automatic model();
      logic [7:0] p, op;
      p = 8'h00;
      for (int i = 0; i < K; i++) begin
         op = mem[p];
         addr_q.push_back(p);
         if (op == HLT_OP) break;
         if (op == JMP || (JZ_EN && op == JZ && zf)) begin
            addr_q.push_back(p + 8'd1);
            p = mem[p + 8'd1];
         end else if (JZ_EN && op == JZ) p = p + 8'd2;
         else begin
            ex_q.push_back(op);
            p = p + 8'd1;
         end
      end
   endtask

   function automatic logic [7:0] pick();
      int r = int'($urandom_range(0, 99));
      return (r < 10) ? JMP : (r < 14) ? HLT_OP : (r < 22) ? JZ : 8'($urandom_range(0, 255));
   endfunction

   initial begin
      logic [16:0] x, a;
      forever begin
         @(negedge clk);
         if (exp_cyc.size() > 0) begin
            x = exp_cyc[0];
            exp_cyc.delete(0);
            a = {pc_mode, mar_load, mem_oe, ir_load, exec_start, busy, halted, x[13] ? bus : 8'h00};
            check(a == x, "trace", int'(a), int'(x));
         end
         if (rnd_mode) begin
            check(!(pc_mode == 3'd2 && mem_oe), "bus_excl", int'(mem_oe), 0);
            if (mar_load) begin
               if (addr_q.size() == 0) check(1'b0, "fetch_extra", int'(bus), -1);
               else begin
                  check(bus == addr_q[0], "fetch_addr", int'(bus), int'(addr_q[0]));
                  addr_q.delete(0);
               end
            end
            if (exec_start && !ex_prev) begin
               if (ex_q.size() == 0) check(1'b0, "exec_extra", int'(ir), -1);
               else begin
                  check(ir == ex_q[0], "exec_op", int'(ir), int'(ex_q[0]));
                  ex_q.delete(0);
               end
            end
         end
         ex_prev = exec_start;
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; halt_force = 1'b0; auto_halt = 1'b0; rnd_mode = 1'b0; zf = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      cyc();
      e(3, IDL);
      cyc();
      reset = 1'b0;
      e(3, IDL);
      cyc();
      // Ordinary opcode then HALT opcode, zero wait.
      mem[0] = 8'h10; mem[1] = HLT_OP;
      e(3, IDL); e(0, BSY); e(2, MA, 8'h00); e(3, OEIR); e(3, BSY); e(3, EX); e(4, BSY);
      e(2, MA, 8'h01); e(3, OEIR); e(3, BSY); e(3, HLT);
      go(11);
      // JMP to 8'h40.
      mem[0] = JMP; mem[1] = 8'h40; mem[8'h40] = HLT_OP;
      trace_jmp();
      go(12);
      // Three wait states, halt_req through INC, restart, then reset mid-READ.
      mem[0] = 8'h10; wait_n = 3; halt_force = 1'b1;
      e(3, HLT); e(0, BSY); e(2, MA, 8'h00); e(3, OE); e(3, OE); e(3, OE); e(3, OEIR);
      e(3, BSY); e(3, EX); e(4, BSY); e(3, HLT);
      e(0, BSY); e(2, MA, 8'h00); e(3, OE); e(3, IDL); e(3, IDL); e(3, IDL); e(0, BSY); e(2, MA, 8'h00);
      go(10);
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc(); cyc();
      #1 reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc();
      wait_halt(50);
      halt_force = 1'b0; wait_n = 0;
`ifdef PC_SEQ_JZ_EN
      mem[0] = JZ; mem[1] = 8'h77; mem[2] = HLT_OP; zf = 1'b0;
      e(3, HLT); e(0, BSY); e(2, MA, 8'h00); e(3, OEIR); e(3, BSY); e(4, BSY); e(4, BSY);
      e(2, MA, 8'h02); e(3, OEIR); e(3, BSY); e(3, HLT);
      go(11);
      mem[1] = 8'h40; mem[8'h40] = HLT_OP; zf = 1'b1;
      trace_jmp();
      go(12);
`endif
      rnd_mode = 1'b1; auto_halt = 1'b1;
      for (int p = 0; p < 25; p++) begin
         for (int i = 0; i < 256; i++) mem[i] = pick();
         K = int'($urandom_range(3, 40));
         zf = 1'($urandom_range(0, 1));
         model();
         start = 1'b1; cyc(); start = 1'b0;
         wait_halt(4000);
         cyc();
         check(addr_q.size() == 0, "fetch_missing", addr_q.size(), 0);
         check(ex_q.size() == 0, "exec_missing", ex_q.size(), 0);
         addr_q.delete();
         ex_q.delete();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/execute sequencer that owns the 8-bit program counter's `pc_mode` control and the shared 8-bit data bus during instruction fetch. It drives the PC onto the bus to address memory, loads the instruction register, and hands non-control opcodes to the execute unit via a request/done handshake. It implements JMP (and optionally JZ) by loading the PC from an operand byte, and it holds or halts the machine on request. It sits between the PC, the memory/MAR, the instruction register and the execute unit in the CPU top level.

## Interface
Parameters:
- `JMP_OPCODE`, 8'h01: opcode whose next byte is the jump target.
- `HALT_OPCODE`, 8'hFF: opcode that stops the sequencer.
- `JZ_OPCODE`, 8'h02: conditional-jump opcode, active only with `PC_SEQ_JZ_EN`.

Ports:
- `clock`  in  1  system clock, all state changes on posedge.
- `reset`  in  1  asynchronous, active-high; forces IDLE.
- `start`  in  1  begins execution from address 0 when in IDLE or HALT.
- `halt_req`  in  1  stop after the current instruction's PC update.
- `mem_ready`  in  1  memory read data valid on bus this cycle.
- `ir_opcode`  in  8  instruction register contents.
- `exec_done`  in  1  execute unit finished.
- `zero_flag`  in  1  ALU zero flag; present only with `PC_SEQ_JZ_EN`.
- `pc_mode`  out  3  PC control: 0 reset, 1 load from bus, 2 drive bus, 3 hold, 4 increment.
- `mar_load`  out  1  memory address register captures bus.
- `mem_oe`  out  1  memory drives bus.
- `ir_load`  out  1  instruction register captures bus.
- `exec_start`  out  1  execute request, level.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
- States: IDLE, CLR, ADDR, READ, DECODE, EXEC, INC, OPINC, OPADDR, OPREAD, HALT (plus SKIP1, SKIP2 with the macro).
- Default outputs: `pc_mode`=3, all strobes 0.
- IDLE: `start` -> CLR.
- CLR: `pc_mode`=0 -> ADDR.
- ADDR: `pc_mode`=2, `mar_load`=1 -> READ.
- READ: `mem_oe`=1. Stay while `mem_ready`=0. When `mem_ready`=1, assert `ir_load`=1 in the same cycle -> DECODE.
- DECODE: one cycle. Branching on `ir_opcode`:
  - `HALT_OPCODE` -> HALT.
  - `JMP_OPCODE` -> OPINC.
  - Any other opcode -> EXEC.
- EXEC: `exec_start`=1 until `exec_done`=1 is sampled -> INC. If `exec_done` is high on the first EXEC cycle, EXEC lasts one cycle.
- INC: `pc_mode`=4. Then HALT if `halt_req`=1, else ADDR.
- OPINC: `pc_mode`=4 -> OPADDR.
- OPADDR: `pc_mode`=2, `mar_load`=1 -> OPREAD.
- OPREAD: `mem_oe`=1. When `mem_ready`=1, also `pc_mode`=1 in that cycle (PC loads the target). Then HALT if `halt_req`=1, else ADDR.
- HALT: `halted`=1. `start` -> CLR. `halt_req` is ignored here.
- Bus rule: at most one of {`pc_mode`==2, `mem_oe`} is asserted in any cycle.
- PC wrap from 8'hFF to 8'h00 is PC behaviour; the sequencer takes no special action.

## Timing
- Reset (async, any state): state IDLE, `pc_mode`=3, all strobes 0, `busy`=0, `halted`=0. This holds until the first posedge after `reset` falls.
- Outputs are decoded from state. The only exceptions are `ir_load` and OPREAD `pc_mode`=1, which are qualified by `mem_ready` in the same cycle.
- Zero-wait memory, one-cycle execute: ordinary instruction takes 5 cycles (ADDR..INC); JMP takes 6 cycles (ADDR..OPREAD).
- Each memory wait cycle adds 1 cycle. Each cycle of `exec_done` low adds 1 cycle.
- `halt_req` is sampled only in INC and in the completing OPREAD cycle. A pulse outside those cycles is lost.
- `start` asserted while busy is ignored.

## Configuration
- `PC_SEQ_JZ_EN` defined:
  - Adds `zero_flag` input.
  - DECODE on `JZ_OPCODE` with `zero_flag`=1 -> OPINC (jump path).
  - DECODE on `JZ_OPCODE` with `zero_flag`=0 -> SKIP1 (`pc_mode`=4) -> SKIP2 (`pc_mode`=4), which skips the operand. Then HALT if `halt_req`, else ADDR.
- Not defined: no `zero_flag` port; `JZ_OPCODE` is treated as an ordinary opcode through EXEC.

## Test plan
- Reset mid-READ with `mem_oe`=1 -> same cycle `mem_oe`=0, `pc_mode`=3, `busy`=0. After release, `start` -> `pc_mode` sequence 0,2.
- `start`, memory returns 8'h10, `exec_done` tied high, zero wait -> `pc_mode` sequence 0,2,3,3,3,4,2. `ir_load` pulses in cycle 4. `exec_start` high one cycle.
- JMP: memory returns 8'h01 then 8'h40 -> OPREAD cycle shows `pc_mode`=1 with `mem_oe`=1. Next ADDR drives 8'h40.
- `mem_ready` low 3 cycles in READ -> `mem_oe` held 4 cycles, `ir_load` only in the 4th. Then `halt_req` held through INC -> HALT, `halted`=1. `start` -> CLR.
- Opcode 8'hFF -> HALT after DECODE with no `exec_start`.
- With `PC_SEQ_JZ_EN`, opcode 8'h02:
  - `zero_flag`=0 -> two `pc_mode`=4 cycles, then ADDR.
  - `zero_flag`=1 -> jump path, as in the JMP scenario.
